// File: rtl/mcu_multiline.sv
// Line-buffer controller: host beat load/unload and parallel chunk access to DEPTH lines.
// Optional abort input enabled by defining MCU_MULTILINE_ABORT_EN.
module mcu_multiline #(
   parameter  int LINE_BITS = 512,
   parameter  int HOST_BITS = 8,
   parameter  int DEPTH     = 4,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
`ifdef MCU_MULTILINE_ABORT_EN
   input  logic                 abort_i,
`endif
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [1:0]           cmd_op_i,
   input  logic [AW-1:0]        cmd_addr_i,
   input  logic [HOST_BITS-1:0] host_in_data_i,
   input  logic                 host_in_valid_i,
   output logic                 host_in_ready_o,
   output logic [HOST_BITS-1:0] host_out_data_o,
   output logic                 host_out_valid_o,
   input  logic                 host_out_ready_i,
   input  logic [LINE_BITS-1:0] chunk_in_i,
   output logic [LINE_BITS-1:0] chunk_out_o,
   output logic                 chunk_out_valid_o,
   output logic                 done_o,
   output logic                 cmd_err_o,
   output logic                 busy_o
);

   // state    | meaning
   // S_IDLE   | waiting for a command, cmd_ready high
   // S_LOAD   | collecting host beats into staging
   // S_UNLOAD | presenting line beats to the host
   // S_CHUNK  | single-cycle parallel write/read completion

   localparam int BEATS = LINE_BITS / HOST_BITS;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UNLOAD, S_CHUNK} state_t;

   state_t               state_q, state_d;
   logic [LINE_BITS-1:0] mem_q [DEPTH];
   logic [LINE_BITS-1:0] staging_q, staged_d;
   logic [LINE_BITS-1:0] chunk_out_q;
   logic [BW-1:0]        beat_q;
   logic [AW-1:0]        addr_q;
   logic                 done_q, err_q, chunk_valid_q;
   logic                 accept, addr_ok, in_fire, out_fire, last_beat, abort_req;

   assign accept    = cmd_valid_i && (state_q == S_IDLE);
   assign addr_ok   = ({1'b0, cmd_addr_i} < DEPTH_W);
   assign in_fire   = host_in_valid_i && (state_q == S_LOAD);
   assign out_fire  = host_out_ready_i && (state_q == S_UNLOAD);
   assign last_beat = (beat_q == LAST_BEAT);

`ifdef MCU_MULTILINE_ABORT_EN
   assign abort_req = abort_i && ((state_q == S_LOAD) || (state_q == S_UNLOAD));
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      staged_d = staging_q;
      staged_d[beat_q*HOST_BITS +: HOST_BITS] = host_in_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d          = state_q;
      cmd_ready_o      = 1'b0;
      busy_o           = 1'b1;
      host_in_ready_o  = 1'b0;
      host_out_valid_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (accept && addr_ok) begin
               case (cmd_op_i)
                  2'b00:   state_d = S_LOAD;
                  2'b01:   state_d = S_UNLOAD;
                  default: state_d = S_CHUNK;
               endcase
            end
         end
         S_LOAD: begin
            host_in_ready_o = 1'b1;
            if (abort_req || (in_fire && last_beat)) state_d = S_IDLE;
         end
         S_UNLOAD: begin
            host_out_valid_o = 1'b1;
            if (abort_req || (out_fire && last_beat)) state_d = S_IDLE;
         end
         S_CHUNK:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         staging_q     <= '0;
         chunk_out_q   <= '0;
         beat_q        <= '0;
         addr_q        <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         chunk_valid_q <= 1'b0;
      end else begin
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         chunk_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  beat_q    <= '0;
                  staging_q <= '0;
                  if (!addr_ok) begin
                     // Rejected address: complete immediately without touching memory.
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else begin
                     addr_q <= cmd_addr_i;
                     if (cmd_op_i == 2'b10) mem_q[cmd_addr_i] <= chunk_in_i;
                     if (cmd_op_i == 2'b11) begin
                        chunk_out_q   <= mem_q[cmd_addr_i];
                        chunk_valid_q <= 1'b1;
                     end
                     if (cmd_op_i[1]) done_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (abort_req) begin
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end else if (in_fire) begin
                  staging_q <= staged_d;
                  beat_q    <= beat_q + BW'(1);
                  if (last_beat) begin
                     mem_q[addr_q] <= staged_d;
                     done_q        <= 1'b1;
                  end
               end
            end
            S_UNLOAD: begin
               if (abort_req) begin
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end else if (out_fire) begin
                  beat_q <= beat_q + BW'(1);
                  if (last_beat) done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign host_out_data_o   = mem_q[addr_q][beat_q*HOST_BITS +: HOST_BITS];
   assign chunk_out_o       = chunk_out_q;
   assign chunk_out_valid_o = chunk_valid_q;
   assign done_o            = done_q;
   assign cmd_err_o         = err_q;

endmodule

// File: tb/tb_mcu_multiline.sv
// Self-checking bench for mcu_multiline: random lines checked against a line-array model.
module tb_mcu_multiline;
   localparam int LB = 512, HB = 8, DP = 5, AW = 3, BEATS = LB / HB;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          cmd_valid = 1'b0, cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [HB-1:0] host_in_data = '0, host_out_data;
   logic          host_in_valid = 1'b0, host_in_ready;
   logic          host_out_valid, host_out_ready = 1'b0;
   logic [LB-1:0] chunk_in = '0, chunk_out;
   logic          chunk_out_valid, done, cmd_err, busy;
`ifdef MCU_MULTILINE_ABORT_EN
   logic          abort = 1'b0;
`endif

   int errors = 0, checks = 0;
   logic [LB-1:0] model [DP];

   mcu_multiline #(.LINE_BITS(LB), .HOST_BITS(HB), .DEPTH(DP)) dut (
      .clk_i(clk), .rst_ni(rst_n),
`ifdef MCU_MULTILINE_ABORT_EN
      .abort_i(abort),
`endif
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr),
      .host_in_data_i(host_in_data), .host_in_valid_i(host_in_valid), .host_in_ready_o(host_in_ready),
      .host_out_data_o(host_out_data), .host_out_valid_o(host_out_valid), .host_out_ready_i(host_out_ready),
      .chunk_in_i(chunk_in), .chunk_out_o(chunk_out), .chunk_out_valid_o(chunk_out_valid),
      .done_o(done), .cmd_err_o(cmd_err), .busy_o(busy));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [LB-1:0] rand_line();
      logic [LB-1:0] l;
      for (int i = 0; i < LB / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [LB-1:0] chunk);
      int n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; chunk_in = chunk;
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      chunk_in  = rand_line();
   endtask

   task automatic do_load(input logic [AW-1:0] addr, input logic [LB-1:0] line, input int gap_pct);
      int k = 0, cyc = 0;
      logic v;
      send_cmd(2'b00, addr, rand_line());
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL load_start: done=%b busy=%b required 0 1", done, busy);
      end
      while (k < BEATS && cyc < 2000) begin
         v = ($urandom_range(0, 99) >= gap_pct);
         host_in_valid = v;
         host_in_data  = v ? line[k*HB +: HB] : HB'($urandom);
         checks++;
         if (host_in_ready !== 1'b1) begin
            errors++; $display("FAIL load_ready: beat %0d host_in_ready=%b required 1", k, host_in_ready);
         end
         @(negedge clk);
         if (v) k++;
         cyc++;
      end
      host_in_valid = 1'b0;
      model[addr] = line;
      checks++;
      if (done !== 1'b1 || cmd_err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL load_done: done=%b err=%b busy=%b required 1 0 0", done, cmd_err, busy);
      end
   endtask

   task automatic do_unload(input logic [AW-1:0] addr, input bit fixed_stall);
      int k = 0, c = 1;
      logic r;
      send_cmd(2'b01, addr, rand_line());
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL unload_start: done=%b required 0", done);
      end
      while (k < BEATS && c < 2000) begin
         r = fixed_stall ? !(c >= 3 && c <= 5) : ($urandom_range(0, 3) != 0);
         host_out_ready = r;
         checks++;
         if (host_out_valid !== 1'b1 || host_out_data !== model[addr][k*HB +: HB]) begin
            errors++;
            $display("FAIL unload_beat: beat %0d valid=%b data=%h required 1 %h",
                     k, host_out_valid, host_out_data, model[addr][k*HB +: HB]);
         end
         @(negedge clk);
         if (r) k++;
         c++;
      end
      host_out_ready = 1'b0;
      checks++;
      if (done !== 1'b1 || cmd_err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL unload_done: done=%b err=%b busy=%b required 1 0 0", done, cmd_err, busy);
      end
   endtask

   task automatic do_chunk_write(input logic [AW-1:0] addr, input logic [LB-1:0] line);
      send_cmd(2'b10, addr, line);
      model[addr] = line;
      checks++;
      if (done !== 1'b1 || cmd_err !== 1'b0 || busy !== 1'b1 || chunk_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL cwr_cycle: done=%b err=%b busy=%b cov=%b required 1 0 1 0", done, cmd_err, busy, chunk_out_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL cwr_after: done=%b busy=%b required 0 0", done, busy);
      end
   endtask

   task automatic do_chunk_read(input logic [AW-1:0] addr);
      send_cmd(2'b11, addr, rand_line());
      checks++;
      if (chunk_out_valid !== 1'b1 || done !== 1'b1 || chunk_out !== model[addr]) begin
         errors++;
         $display("FAIL crd_cycle: addr %0d cov=%b done=%b data=%h required 1 1 %h",
                  addr, chunk_out_valid, done, chunk_out, model[addr]);
      end
      @(negedge clk);
      checks++;
      if (chunk_out_valid !== 1'b0 || done !== 1'b0 || chunk_out !== model[addr]) begin
         errors++;
         $display("FAIL crd_hold: cov=%b done=%b data=%h required 0 0 %h", chunk_out_valid, done, chunk_out, model[addr]);
      end
   endtask

   task automatic verify_all();
      for (int a = 0; a < DP; a++) do_chunk_read(AW'(a));
   endtask

   task automatic test_reset();
      for (int a = 0; a < DP; a++) model[a] = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0 ||
          chunk_out_valid !== 1'b0 || host_out_valid !== 1'b0 || host_in_ready !== 1'b0 || chunk_out !== '0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b busy=%b done=%b err=%b cov=%b hov=%b hir=%b required 1 0 0 0 0 0 0",
                  cmd_ready, busy, done, cmd_err, chunk_out_valid, host_out_valid, host_in_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
      verify_all();
   endtask

   task automatic test_load_counting();
      logic [LB-1:0] l;
      for (int k = 0; k < BEATS; k++) l[k*HB +: HB] = HB'(k);
      do_load(3'd2, l, 30);
      do_chunk_read(3'd2);
   endtask

   task automatic test_stalled_unload();
      do_chunk_write(3'd1, {64{8'hA5}});
      do_unload(3'd1, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         logic [AW-1:0] a = AW'($urandom_range(0, DP - 1));
         case ($urandom_range(0, 3))
            0: do_load(a, rand_line(), 40);
            1: do_unload(a, 1'b0);
            2: do_chunk_write(a, rand_line());
            default: do_chunk_read(a);
         endcase
      end
      do_load(3'd4, rand_line(), 0);
      do_unload(3'd4, 1'b0);
      do_chunk_read(3'd4);
   endtask

   task automatic test_ignore();
      for (int i = 0; i < 4; i++) begin
         host_in_valid = 1'b1; host_in_data = HB'($urandom); host_out_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || host_in_ready !== 1'b0 || host_out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: busy=%b hir=%b hov=%b done=%b required 0 0 0 0", busy, host_in_ready, host_out_valid, done);
         end
      end
      host_in_valid = 1'b0; host_out_ready = 1'b0;
      verify_all();
   endtask

   task automatic test_bad_addr();
      for (int a = DP; a < 8; a++) begin
         send_cmd(2'($urandom_range(0, 3)), AW'(a), rand_line());
         checks++;
         if (done !== 1'b1 || cmd_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bad_addr: addr %0d done=%b err=%b busy=%b required 1 1 0", a, done, cmd_err, busy);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || cmd_err !== 1'b0) begin
            errors++; $display("FAIL bad_addr_pulse: done=%b err=%b required 0 0", done, cmd_err);
         end
      end
      verify_all();
   endtask

   task automatic test_abort();
`ifdef MCU_MULTILINE_ABORT_EN
      int k = 0;
      model[3] = '0;
      do_chunk_write(3'd3, '0);
      send_cmd(2'b00, 3'd3, rand_line());
      while (k < 10) begin
         host_in_valid = 1'b1; host_in_data = HB'($urandom);
         @(negedge clk); k++;
      end
      host_in_valid = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (done !== 1'b1 || cmd_err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL abort: done=%b err=%b busy=%b required 1 1 0", done, cmd_err, busy);
      end
      @(negedge clk);
      do_chunk_read(3'd3);
`else
      do_load(3'd3, rand_line(), 20);
      do_chunk_read(3'd3);
`endif
   endtask

   task automatic test_reset_mid_load();
      send_cmd(2'b00, 3'd0, rand_line());
      for (int k = 0; k < 20; k++) begin
         host_in_valid = 1'b1; host_in_data = HB'($urandom);
         @(negedge clk);
      end
      host_in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int a = 0; a < DP; a++) model[a] = '0;
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || host_in_ready !== 1'b0 || done !== 1'b0 || chunk_out !== '0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b rdy=%b hir=%b done=%b required 0 1 0 0", busy, cmd_ready, host_in_ready, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL reset_mid_done: done=%b required 0", done);
      end
      do_unload(3'd0, 1'b0);
      @(negedge clk);
      verify_all();
   endtask

   initial begin
      test_reset();
      test_load_counting();
      test_stalled_unload();
      test_back_to_back();
      test_ignore();
      test_bad_addr();
      test_abort();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mcu_multiline.md
MCU_MULTILINE -- requirements
Module: mcu_multiline

Interface
REQ-001 Parameter LINE_BITS, default 512, SHALL set the width of one memory line.
REQ-002 Parameter HOST_BITS, default 8, SHALL set the host beat width; LINE_BITS SHALL be an integer multiple of HOST_BITS, so BEATS = LINE_BITS/HOST_BITS.
REQ-003 Parameter DEPTH, default 4, SHALL set the number of lines held; AW = max(1, clog2(DEPTH)).
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1 / cmd_ready  out  1  command handshake; a command is accepted when both are high.
REQ-007 cmd_op  in  2  operation: 00 host load, 01 host unload, 10 chunk write, 11 chunk read.
REQ-008 cmd_addr  in  AW  target line.
REQ-009 host_in_data  in  HOST_BITS / host_in_valid  in  1 / host_in_ready  out  1  host-to-memory beat stream.
REQ-010 host_out_data  out  HOST_BITS / host_out_valid  out  1 / host_out_ready  in  1  memory-to-host beat stream.
REQ-011 chunk_in  in  LINE_BITS  parallel line write data; chunk_out  out  LINE_BITS  parallel line read data; chunk_out_valid  out  1  one-cycle qualifier.
REQ-012 done  out  1  one-cycle completion pulse; cmd_err  out  1  qualifies done for a rejected address; busy  out  1  high in any non-IDLE state.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, UNLOAD, CHUNK; cmd_ready SHALL be high only in IDLE.
REQ-014 Acceptance with op 00 SHALL enter LOAD, with op 01 UNLOAD, with op 10/11 CHUNK; the beat counter SHALL clear and the address SHALL latch at acceptance.
REQ-015 In LOAD, host_in_ready SHALL be high; beat k, accepted on host_in_valid & host_in_ready, SHALL land in staging bits [k*HOST_BITS +: HOST_BITS], beat 0 = LSBs.
REQ-016 When beat BEATS-1 is accepted, the staged line SHALL be written to the latched line on that edge, and the FSM SHALL return to IDLE with done high for the following cycle.
REQ-017 In UNLOAD, host_out_valid SHALL be high from the cycle after acceptance, host_out_data SHALL present beat k of the line, k SHALL advance only on host_out_valid & host_out_ready, and data SHALL hold stable while stalled.
REQ-018 When beat BEATS-1 is accepted in UNLOAD, the FSM SHALL return to IDLE and done SHALL pulse the following cycle.
REQ-019 Chunk write SHALL store chunk_in, sampled at acceptance, into the line; CHUNK SHALL last exactly one cycle, and done SHALL be high in that cycle.
REQ-020 Chunk read SHALL drive chunk_out with the line and chunk_out_valid high in the CHUNK cycle, which is one cycle after acceptance; chunk_out SHALL hold its value until the next chunk read.
REQ-021 A cmd_addr >= DEPTH SHALL be accepted, SHALL change no memory, SHALL skip streaming, and SHALL return to IDLE with done and cmd_err high one cycle after acceptance.
REQ-022 host_in_valid in a non-LOAD state and host_out_ready in a non-UNLOAD state SHALL be ignored.
REQ-023 An unload of a line never written SHALL return zeros.
REQ-024 Back-to-back commands SHALL be legal: a command presented in the cycle done is high SHALL be accepted.

Reset
REQ-025 While rst is low: FSM = IDLE; counter, staging and every memory line = 0; chunk_out = 0; done, cmd_err, chunk_out_valid, host_out_valid, host_in_ready and busy = 0; cmd_ready = 1.
REQ-026 Reset mid-LOAD SHALL discard the staged beats, leave the target line zero, and produce no done.

Configuration
REQ-027 Macro MCU_MULTILINE_ABORT_EN defined: input abort (1 bit) SHALL exist, and abort high in LOAD or UNLOAD SHALL return to IDLE next cycle with done and cmd_err pulsed and memory unchanged.
REQ-028 Macro MCU_MULTILINE_ABORT_EN undefined: the abort port SHALL be absent and transfers SHALL complete only per REQ-016/REQ-018.

Verification
REQ-029 Load addr 2 with beats 0x00..0x3F, then chunk read addr 2 -> chunk_out byte k = k; done pulses once per command.
REQ-030 Chunk write addr 1 = {64{0xA5}}, then unload with host_out_ready low for cycles 3-5 -> 64 beats of 0xA5, data held while stalled, done after the last beat.
REQ-031 Command with cmd_addr = 5 when DEPTH = 5 -> done & cmd_err one cycle after acceptance; all lines unchanged.
REQ-032 rst low after 20 load beats to addr 0, then unload addr 0 -> 64 zero beats.
REQ-033 With MCU_MULTILINE_ABORT_EN, abort at beat 10 of load addr 3 -> IDLE next cycle, done & cmd_err, line 3 still zero; without the macro the same load completes normally.
